// File: rtl/usb_fs_pkg.sv
// Shared definitions for the USB FS IN-endpoint arbiter: data width,
// ID-width helper and the arbiter state encoding.
package usb_fs_pkg;

    localparam int USB_FS_DATA_W = 8;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

    // Width needed to index n endpoints, never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_fs_in_rr_arb_if.sv
// Bundle between the IN endpoints / protocol engine and the IN arbiter.
// master: the arbiter side; slave: the endpoints and engine side.
interface usb_fs_in_rr_arb_if #(
    parameter int NUM_IN_EPS = 4,
    parameter int DATA_W     = usb_fs_pkg::USB_FS_DATA_W
);
    import usb_fs_pkg::*;

    localparam int ID_W = id_width(NUM_IN_EPS);

    logic [NUM_IN_EPS-1:0]        in_ep_req;
    logic [NUM_IN_EPS-1:0]        in_ep_grant;
    logic [NUM_IN_EPS*DATA_W-1:0] in_ep_data;
    logic                         in_xfr_end;
    logic [DATA_W-1:0]            arb_in_ep_data;
    logic                         arb_in_ep_valid;
    logic [ID_W-1:0]              arb_in_ep_id;

    modport master (
        input  in_ep_req, in_ep_data, in_xfr_end,
        output in_ep_grant, arb_in_ep_data, arb_in_ep_valid, arb_in_ep_id
    );

    modport slave (
        output in_ep_req, in_ep_data, in_xfr_end,
        input  in_ep_grant, arb_in_ep_data, arb_in_ep_valid, arb_in_ep_id
    );

endinterface

// File: rtl/usb_fs_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so the
// start pointer lands on bit 0, priority-encodes the lowest set bit, and
// maps the offset back to an absolute endpoint index.
module usb_fs_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] winner
);

    logic [N-1:0] rot;
    int           off;
    int           sum;

    // Rotate via the doubled vector, then find the first requester at or after ptr.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        found = |req;
        off   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = ID_W'(sum);
    end

endmodule

// File: rtl/usb_fs_in_rr_arb.sv
// USB FS IN-endpoint arbiter. Grants one endpoint at a time with registered
// one-hot grants, holds the grant for the whole packet and always inserts one
// idle cycle between grants as bus turnaround for the protocol engine.
module usb_fs_in_rr_arb
    import usb_fs_pkg::*;
#(
    parameter int NUM_IN_EPS = 4,
    parameter int DATA_W     = USB_FS_DATA_W,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    usb_fs_in_rr_arb_if.master    bus
);

    localparam int ID_W = id_width(NUM_IN_EPS);

    arb_state_e            state_q, state_d;
    logic [NUM_IN_EPS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  valid_q, valid_d;

    logic [ID_W-1:0]       pick_ptr;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_found;
    logic                  release_hit;
    logic [ID_W-1:0]       ptr_after;
    logic [DATA_W-1:0]     data_mux;

    // Fixed priority reuses the same picker with the search starting at 0.
    assign pick_ptr = RR_EN ? ptr_q : '0;

    usb_fs_rr_pick #(
        .N    (NUM_IN_EPS),
        .ID_W (ID_W)
    ) u_pick (
        .req    (bus.in_ep_req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .winner (pick_id)
    );

    // Next-state: select in IDLE, hold until packet end or request drop in GRANTED.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        id_d        = id_q;
        valid_d     = valid_q;
        ptr_d       = ptr_q;
        // A dropped request and an end pulse together still form one release.
        release_hit = bus.in_xfr_end || ((bus.in_ep_req & grant_q) == '0);
        ptr_after   = (id_q == ID_W'(NUM_IN_EPS - 1)) ? '0 : id_q + 1'b1;

        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                state_d = ARB_GRANTED;
                grant_d = NUM_IN_EPS'(1) << pick_id;
                id_d    = pick_id;
                valid_d = 1'b1;
            end
        end else begin
            if (release_hit) begin
                state_d = ARB_IDLE;
                grant_d = '0;
                id_d    = '0;
                valid_d = 1'b0;
                if (RR_EN) begin
                    ptr_d = ptr_after;
                end
            end
        end
    end

    // State, grant outputs and round-robin pointer; reset drops any grant at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Data of the granted endpoint straight from the registered grant; zero when idle.
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (grant_q[i]) begin
                data_mux = bus.in_ep_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.in_ep_grant     = grant_q;
    assign bus.arb_in_ep_valid = valid_q;
    assign bus.arb_in_ep_id    = id_q;
    assign bus.arb_in_ep_data  = data_mux;

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Bench for usb_fs_in_rr_arb: a round-robin and a fixed-priority instance
// share the same stimulus and are compared each cycle against a behavioural
// model built from endpoint ownership and a search pointer.
module tb_usb_fs_in_rr_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        xfr_end;

    int vectors     = 0;
    int miscompares = 0;

    // Model: owner endpoint per instance (-1 = idle) and search pointer.
    int m_own [2] = '{-1, -1};
    int m_ptr [2] = '{0, 0};

    always #5 clk = ~clk;

    usb_fs_in_rr_arb_if #(.NUM_IN_EPS(4), .DATA_W(8)) bus_rr ();
    usb_fs_in_rr_arb_if #(.NUM_IN_EPS(4), .DATA_W(8)) bus_fx ();

    assign bus_rr.in_ep_req  = req;
    assign bus_rr.in_ep_data = data;
    assign bus_rr.in_xfr_end = xfr_end;
    assign bus_fx.in_ep_req  = req;
    assign bus_fx.in_ep_data = data;
    assign bus_fx.in_xfr_end = xfr_end;

    usb_fs_in_rr_arb #(.NUM_IN_EPS(4), .DATA_W(8), .RR_EN(1'b1)) dut_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_rr)
    );

    usb_fs_in_rr_arb #(.NUM_IN_EPS(4), .DATA_W(8), .RR_EN(1'b0)) dut_fx (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_fx)
    );

    logic [14:0] obs_rr, obs_fx;
    assign obs_rr = {bus_rr.in_ep_grant, bus_rr.arb_in_ep_valid, bus_rr.arb_in_ep_id, bus_rr.arb_in_ep_data};
    assign obs_fx = {bus_fx.in_ep_grant, bus_fx.arb_in_ep_valid, bus_fx.arb_in_ep_id, bus_fx.arb_in_ep_data};

    // Reference behaviour: who owns the bus after each edge.
    always @(posedge clk) begin
        int c;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_own[k] = -1;
                m_ptr[k] = 0;
            end else if (m_own[k] < 0) begin
                for (int j = 0; j < 4; j++) begin
                    c = (m_ptr[k] + j) % 4;
                    if (req[c] && m_own[k] < 0) m_own[k] = c;
                end
            end else if (xfr_end || !req[m_own[k]]) begin
                if (k == 0) m_ptr[k] = (m_own[k] + 1) % 4;
                m_own[k] = -1;
            end
        end
    end

    function automatic logic [14:0] exp_vec(input int k);
        logic [3:0] g;
        if (m_own[k] < 0) return 15'h0;
        g = 4'b0001 << m_own[k];
        return {g, 1'b1, 2'(m_own[k]), data[m_own[k]*8 +: 8]};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; req = 4'b1111; xfr_end = 1'b0; data = $urandom;
        repeat (3) begin
            @(negedge clk);
            vectors++; if (obs_rr !== 15'h0) begin miscompares++; $display("FAIL reset_rr got=%h want=0000", obs_rr); end
            vectors++; if (obs_fx !== 15'h0) begin miscompares++; $display("FAIL reset_fx got=%h want=0000", obs_fx); end
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus_rr.in_ep_grant !== 4'b0001) begin miscompares++; $display("FAIL reset_release_grant got=%b want=0001", bus_rr.in_ep_grant); end
        vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL reset_release_rr got=%h want=%h", obs_rr, exp_vec(0)); end
        vectors++; if (obs_fx !== exp_vec(1)) begin miscompares++; $display("FAIL reset_release_fx got=%h want=%h", obs_fx, exp_vec(1)); end
    endtask

    task automatic test_rr_rotation();
        logic [3:0] want;
        for (int g = 0; g < 5; g++) begin
            want = 4'b0001 << (g % 4);
            vectors++; if (bus_rr.in_ep_grant !== want) begin miscompares++; $display("FAIL rr_order[%0d] got=%b want=%b", g, bus_rr.in_ep_grant, want); end
            repeat (3) begin
                data = $urandom;
                @(negedge clk);
                vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL rot_rr got=%h want=%h", obs_rr, exp_vec(0)); end
                vectors++; if (obs_fx !== exp_vec(1)) begin miscompares++; $display("FAIL rot_fx got=%h want=%h", obs_fx, exp_vec(1)); end
            end
            xfr_end = 1'b1;
            @(negedge clk);
            xfr_end = 1'b0;
            vectors++; if (bus_rr.in_ep_grant !== 4'b0000) begin miscompares++; $display("FAIL rr_gap[%0d] got=%b want=0000", g, bus_rr.in_ep_grant); end
            vectors++; if (obs_fx !== exp_vec(1)) begin miscompares++; $display("FAIL rot_gap_fx got=%h want=%h", obs_fx, exp_vec(1)); end
            @(negedge clk);
            vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL rot_regrant_rr got=%h want=%h", obs_rr, exp_vec(0)); end
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        vectors++; if (obs_rr !== 15'h0 || obs_fx !== 15'h0) begin miscompares++; $display("FAIL rot_idle got=%h/%h want=0000", obs_rr, obs_fx); end
    endtask

    task automatic test_lock_mux();
        req = 4'b0100; data = $urandom; data[23:16] = 8'hA5;
        @(negedge clk);
        vectors++; if (bus_rr.in_ep_grant !== 4'b0100) begin miscompares++; $display("FAIL lock_grant got=%b want=0100", bus_rr.in_ep_grant); end
        req = 4'b0101;
        repeat (4) begin
            data = $urandom; data[23:16] = 8'hA5;
            @(negedge clk);
            vectors++; if ({bus_rr.in_ep_grant, bus_rr.arb_in_ep_id, bus_rr.arb_in_ep_data} !== {4'b0100, 2'd2, 8'hA5}) begin
                miscompares++; $display("FAIL lock_hold got=%b/%0d/%h want=0100/2/a5", bus_rr.in_ep_grant, bus_rr.arb_in_ep_id, bus_rr.arb_in_ep_data);
            end
            vectors++; if (obs_fx !== exp_vec(1)) begin miscompares++; $display("FAIL lock_fx got=%h want=%h", obs_fx, exp_vec(1)); end
        end
        req = 4'b0001;
        @(negedge clk);
        vectors++; if (obs_rr !== 15'h0) begin miscompares++; $display("FAIL lock_release got=%h want=0000", obs_rr); end
        @(negedge clk);
        vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL lock_next_rr got=%h want=%h", obs_rr, exp_vec(0)); end
        vectors++; if (obs_fx !== exp_vec(1)) begin miscompares++; $display("FAIL lock_next_fx got=%h want=%h", obs_fx, exp_vec(1)); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simul_release();
        req = 4'b0010; data = $urandom;
        @(negedge clk);
        vectors++; if (bus_rr.in_ep_grant !== 4'b0010) begin miscompares++; $display("FAIL simul_grant got=%b want=0010", bus_rr.in_ep_grant); end
        req = 4'b1011;
        repeat (2) begin
            @(negedge clk);
            vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL simul_hold_rr got=%h want=%h", obs_rr, exp_vec(0)); end
        end
        req = 4'b1001; xfr_end = 1'b1;
        @(negedge clk);
        xfr_end = 1'b0;
        vectors++; if (bus_rr.in_ep_grant !== 4'b0000) begin miscompares++; $display("FAIL simul_idle got=%b want=0000", bus_rr.in_ep_grant); end
        @(negedge clk);
        vectors++; if ({bus_rr.in_ep_grant, bus_rr.arb_in_ep_id} !== {4'b1000, 2'd3}) begin
            miscompares++; $display("FAIL simul_next got=%b/%0d want=1000/3", bus_rr.in_ep_grant, bus_rr.arb_in_ep_id);
        end
        vectors++; if (obs_fx !== exp_vec(1)) begin miscompares++; $display("FAIL simul_next_fx got=%h want=%h", obs_fx, exp_vec(1)); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed();
        req = 4'b1010;
        repeat (3) begin
            data = $urandom;
            @(negedge clk);
            vectors++; if (bus_fx.in_ep_grant !== 4'b0010) begin miscompares++; $display("FAIL fixed_grant got=%b want=0010", bus_fx.in_ep_grant); end
            vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL fixed_rr got=%h want=%h", obs_rr, exp_vec(0)); end
            @(negedge clk);
            xfr_end = 1'b1;
            @(negedge clk);
            xfr_end = 1'b0;
            vectors++; if (obs_fx !== 15'h0) begin miscompares++; $display("FAIL fixed_idle got=%h want=0000", obs_fx); end
        end
        @(negedge clk);
        vectors++; if (bus_fx.in_ep_grant !== 4'b0010) begin miscompares++; $display("FAIL fixed_grant_last got=%b want=0010", bus_fx.in_ep_grant); end
        req = 4'b1000; xfr_end = 1'b1;
        @(negedge clk);
        xfr_end = 1'b0;
        @(negedge clk);
        vectors++; if (bus_fx.in_ep_grant !== 4'b1000) begin miscompares++; $display("FAIL fixed_ep3 got=%b want=1000", bus_fx.in_ep_grant); end
        vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL fixed_end_rr got=%h want=%h", obs_rr, exp_vec(0)); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req = 4'b1000; data = $urandom;
        @(negedge clk);
        vectors++; if (bus_rr.in_ep_grant !== 4'b1000) begin miscompares++; $display("FAIL mid_grant got=%b want=1000", bus_rr.in_ep_grant); end
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++; if (obs_rr !== 15'h0 || obs_fx !== 15'h0) begin miscompares++; $display("FAIL mid_reset got=%h/%h want=0000", obs_rr, obs_fx); end
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus_rr.in_ep_grant !== 4'b1000) begin miscompares++; $display("FAIL mid_regrant got=%b want=1000", bus_rr.in_ep_grant); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        // Move the pointer to 2, then reset while idle: pointer must restart at 0.
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1; req = 4'b0101;
        @(negedge clk);
        vectors++; if (bus_rr.in_ep_grant !== 4'b0001) begin miscompares++; $display("FAIL ptr_after_reset got=%b want=0001", bus_rr.in_ep_grant); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            vectors++; if (obs_rr !== exp_vec(0)) begin miscompares++; $display("FAIL rand_rr[%0d] got=%h want=%h", n, obs_rr, exp_vec(0)); end
            vectors++; if (obs_fx !== exp_vec(1)) begin miscompares++; $display("FAIL rand_fx[%0d] got=%h want=%h", n, obs_fx, exp_vec(1)); end
            vectors++; if (!$onehot0(bus_rr.in_ep_grant)) begin miscompares++; $display("FAIL rand_onehot got=%b want=zero-or-one-hot", bus_rr.in_ep_grant); end
            reset_n = ($urandom_range(0, 99) != 0);
            xfr_end = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            data = $urandom;
        end
        reset_n = 1'b1; xfr_end = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; req = 4'b0000; data = 32'h0; xfr_end = 1'b0;
        test_reset();
        test_rr_rotation();
        test_lock_mux();
        test_simul_release();
        test_fixed();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_fs_in_rr_arb.md
Name: usb_fs_in_rr_arb

Overview:
Parametrised successor to the fixed-priority USB FS IN-endpoint arbiter. Selects one of NUM_IN_EPS IN endpoints to feed the protocol engine, with registered grants and a round-robin (or optional fixed) priority. Once granted, an endpoint keeps the grant for the whole packet. Sits between the IN endpoint instances and the USB FS IN protocol engine.

Parameters:
NUM_IN_EPS, 4, number of IN endpoints arbitrated (1..16)
DATA_W, 8, per-endpoint data width in bits
RR_EN, 1, 1 = round-robin priority; 0 = fixed priority (lowest index wins)
ID_W, derived localparam (not overridable), max(1, clog2(NUM_IN_EPS))

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
in_ep_req  in  NUM_IN_EPS  per-endpoint request; held high for the whole packet
in_ep_grant  out  NUM_IN_EPS  registered one-hot grant (all-zero when idle)
in_ep_data  in  NUM_IN_EPS*DATA_W  packed endpoint data; endpoint i occupies [i*DATA_W +: DATA_W]
in_xfr_end  in  1  single-cycle pulse from the protocol engine at packet end (ACK, timeout or abort)
arb_in_ep_data  out  DATA_W  data of the granted endpoint, 0 when idle
arb_in_ep_valid  out  1  high while any grant is held
arb_in_ep_id  out  ID_W  index of the granted endpoint, 0 when idle

Behaviour:
- Reset (reset_n sampled low on a clk edge):
  - in_ep_grant=0, arb_in_ep_valid=0, arb_in_ep_id=0, rr pointer=0, state=IDLE.
  - Reset mid-packet drops the grant immediately, with no release pulse.
- State IDLE:
  - If in_ep_req != 0, choose a winner.
    - RR_EN=1: first requester found searching upward from the rr pointer, wrapping from NUM_IN_EPS-1 to 0.
    - RR_EN=0: lowest requesting index.
  - Next edge: in_ep_grant = onehot(winner), arb_in_ep_id = winner, arb_in_ep_valid=1, state=GRANTED.
  - Arbitration latency is exactly 1 clk from req seen to grant.
- State GRANTED:
  - Grant is locked; requests from other endpoints are ignored.
  - Release condition: in_xfr_end=1, or in_ep_req[winner]=0.
  - On release, the next edge clears the grant outputs, returns to IDLE, and (RR_EN=1) sets the pointer to (winner+1) mod NUM_IN_EPS.
  - Wrap case: winner = NUM_IN_EPS-1 sets the pointer to 0.
  - Both release causes in the same cycle count as one release.
  - At least one idle cycle always separates consecutive grants. This is the bus turnaround for the engine.
- Data path:
  - arb_in_ep_data is combinational from the registered grant: in_ep_data slice at arb_in_ep_id when valid, else 0. No added data latency.
- Invariants:
  - in_ep_grant is always zero- or one-hot.
  - The grant bit only asserts for an endpoint whose req was high in the selecting cycle.
  - in_xfr_end while IDLE is ignored.
- NUM_IN_EPS=1: degenerates to grant-follows-req with 1-cycle latency and the same release rules. arb_in_ep_id is tied to 0.
- No starvation (RR_EN=1): a continuously requesting endpoint is granted within NUM_IN_EPS grants.

Decomposition:
- Shared package usb_fs_pkg:
  - USB_FS_DATA_W = 8
  - clog2-style ID width function
  - arbiter state encoding (IDLE=1'b0, GRANTED=1'b1)
- One natural sub-module: usb_fs_rr_pick.
  - Combinational: given req vector and start pointer, returns found flag and winner index.
  - Implemented as a doubled-vector rotate plus priority encode.
  - Reused with pointer forced to 0 for RR_EN=0.
- The top holds the FSM, the pointer register and the output mux.

Test Plan:
1. Reset/idle: hold reset_n=0 with in_ep_req=4'b1111 for 3 clks -> grant=0, valid=0, id=0 throughout. Release reset -> grant=4'b0001 one clk later.
2. Round-robin rotation (RR_EN=1, N=4): keep req=4'b1111, pulse in_xfr_end 4 cycles after each grant -> grant order EP0, EP1, EP2, EP3, EP0, with exactly one idle cycle between grants.
3. Lock and data mux: EP2 granted with in_ep_data[23:16]=8'hA5, then raise req[0] -> grant stays 4'b0100, arb_in_ep_data=8'hA5, id=2 until release.
4. Request drop and simultaneous release: EP1 drops req in the same cycle as the in_xfr_end pulse -> a single release, pointer=2. With req=4'b1001 pending, next grant=4'b1000 (EP3).
5. Fixed mode (RR_EN=0): req=4'b1010 repeatedly, each packet released by in_xfr_end -> every grant goes to EP1. EP3 is granted only once req[1]=0.
6. Reset mid-packet: assert reset_n=0 while EP3 is granted -> next edge grant=0, pointer=0. After reset, with req=4'b1000, EP3 is re-granted one clk after reset_n rises.
